// File: rtl/lif_neuron_chain_if.sv
// Control and observation bundle of the LIF neuron chain: network inputs and registered outputs.
interface lif_neuron_chain_if #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned WIDTH     = 8
);
    logic                           enable;
    logic [WIDTH-1:0]               stim_in;
    logic [(N_NEURONS-1)*WIDTH-1:0] weights;
    logic [WIDTH-1:0]               threshold;
    logic [2:0]                     leak_shift;
    logic [N_NEURONS-1:0]           spikes;
    logic                           spike_output;
    logic [15:0]                    spike_count;

    modport master (
        output enable, stim_in, weights, threshold, leak_shift,
        input  spikes, spike_output, spike_count
    );

    modport slave (
        input  enable, stim_in, weights, threshold, leak_shift,
        output spikes, spike_output, spike_count
    );
endinterface

// File: rtl/lif_neuron_chain.sv
// Chain of leaky integrate-and-fire neurons linked by one-cycle weighted synapses.
// Optional refractory counter per neuron is built when LIF_REFRACTORY_EN is defined.
module lif_neuron_chain #(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned REFRACT   = 3
) (
    input logic               clk,
    input logic               reset,
    lif_neuron_chain_if.slave bus
);
    if (N_NEURONS < 2 || REFRACT < 1) begin : g_cfg_check
        $error("lif_neuron_chain: N_NEURONS must be >= 2 and REFRACT >= 1");
    end

    logic [WIDTH-1:0]     v_q [N_NEURONS];
    logic [WIDTH-1:0]     v_d [N_NEURONS];
    logic [N_NEURONS-1:0] spikes_q, spikes_d;
    logic                 spike_output_q, spike_output_d;
    logic [15:0]          spike_count_q, spike_count_d;

`ifdef LIF_REFRACTORY_EN
    localparam int unsigned RW = $clog2(REFRACT + 1);
    logic [RW-1:0] refr_q [N_NEURONS];
    logic [RW-1:0] refr_d [N_NEURONS];
`endif

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
        logic [WIDTH-1:0] syn_in;
        logic [WIDTH-1:0] leak;
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] v_sat;
        logic             fire;

        // Synapse reads the upstream spike register, giving exactly one cycle of delay.
        if (i == 0) begin : g_src
            assign syn_in = bus.stim_in;
        end else begin : g_syn
            assign syn_in = spikes_q[i-1] ? bus.weights[(i-1)*WIDTH +: WIDTH] : '0;
        end

        assign leak  = (bus.leak_shift == 3'd0) ? '0 : (v_q[i] >> bus.leak_shift);
        assign sum   = {1'b0, v_q[i]} - {1'b0, leak} + {1'b0, syn_in};
        assign v_sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        assign fire  = (v_sat >= bus.threshold);

`ifdef LIF_REFRACTORY_EN
        logic busy;
        assign busy = (refr_q[i] != '0);

        always_comb begin
            v_d[i]      = v_q[i];
            refr_d[i]   = refr_q[i];
            spikes_d[i] = 1'b0;
            if (bus.enable) begin
                if (busy) begin
                    refr_d[i] = refr_q[i] - RW'(1);
                    v_d[i]    = '0;
                end else if (fire) begin
                    spikes_d[i] = 1'b1;
                    v_d[i]      = '0;
                    refr_d[i]   = RW'(REFRACT);
                end else begin
                    v_d[i] = v_sat;
                end
            end
        end
`else
        always_comb begin
            v_d[i]      = v_q[i];
            spikes_d[i] = 1'b0;
            if (bus.enable) begin
                spikes_d[i] = fire;
                v_d[i]      = fire ? '0 : v_sat;
            end
        end
`endif
    end

    always_comb begin
        spike_output_d = bus.enable & spikes_q[N_NEURONS-1];
        spike_count_d  = spike_count_q;
        if (spike_output_q && (spike_count_q != 16'hFFFF)) begin
            spike_count_d = spike_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q            <= '{default: '0};
            spikes_q       <= '0;
            spike_output_q <= 1'b0;
            spike_count_q  <= '0;
`ifdef LIF_REFRACTORY_EN
            refr_q         <= '{default: '0};
`endif
        end else begin
            v_q            <= v_d;
            spikes_q       <= spikes_d;
            spike_output_q <= spike_output_d;
            spike_count_q  <= spike_count_d;
`ifdef LIF_REFRACTORY_EN
            refr_q         <= refr_d;
`endif
        end
    end

    assign bus.spikes       = spikes_q;
    assign bus.spike_output = spike_output_q;
    assign bus.spike_count  = spike_count_q;
endmodule

// File: tb/tb_lif_neuron_chain.sv
// Bench for lif_neuron_chain: directed scenarios plus randomized traffic against an integer model.
module tb_lif_neuron_chain;
    localparam int N = 4;
    localparam int W = 8;
    localparam int R = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lif_neuron_chain_if #(.N_NEURONS(N), .WIDTH(W)) bus ();

    lif_neuron_chain #(.N_NEURONS(N), .WIDTH(W), .REFRACT(R)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         m_v    [N];
    int         m_refr [N];
    bit [N-1:0] m_spk;
    bit         m_out;
    int         m_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;

    // Reference: spec rules evaluated with integer arithmetic on the inputs seen at the edge.
    task automatic model_edge();
        bit [N-1:0] ns;
        int inp, lk, nv;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_v[i] = 0;
                m_refr[i] = 0;
            end
            m_spk = '0;
            m_out = 1'b0;
            m_cnt = 0;
            return;
        end
        if (m_out && m_cnt < 65535) m_cnt++;
        if (!bus.enable) begin
            m_spk = '0;
            m_out = 1'b0;
            return;
        end
        ns = '0;
        for (int i = 0; i < N; i++) begin
`ifdef LIF_REFRACTORY_EN
            if (m_refr[i] > 0) begin
                m_refr[i]--;
                m_v[i] = 0;
                continue;
            end
`endif
            inp = 0;
            if (i == 0) inp = int'(bus.stim_in);
            else if (m_spk[i-1]) inp = int'(bus.weights[(i-1)*W +: W]);
            lk = (bus.leak_shift == 0) ? 0 : (m_v[i] >> bus.leak_shift);
            nv = m_v[i] - lk + inp;
            if (nv > 255) nv = 255;
            if (nv >= int'(bus.threshold)) begin
                ns[i] = 1'b1;
                m_v[i] = 0;
                m_refr[i] = R;
            end else begin
                m_v[i] = nv;
            end
        end
        m_out = m_spk[N-1];
        m_spk = ns;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input bit en, input int stim, input int w, input int thr, input int ls);
        bus.enable     = en;
        bus.stim_in    = W'(stim);
        bus.weights    = {W'(w), W'(w), W'(w)};
        bus.threshold  = W'(thr);
        bus.leak_shift = 3'(ls);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_in(1'b1, 255, 255, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus.spikes, bus.spike_output, bus.spike_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got spikes=%b out=%b cnt=%0d, want all 0",
                     bus.spikes, bus.spike_output, bus.spike_count);
        end
        reset = 1'b0;
    endtask

    task automatic test_integrate();
        do_reset();
        set_in(1'b1, 25, 0, 100, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (bus.spikes[0] !== (k == 4)) begin
                n_bad++;
                $display("FAIL integrate_edge%0d: got spike0=%b, want %b", k, bus.spikes[0], k == 4);
            end
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_cmp++;
            if (bus.spikes !== m_spk) begin
                n_bad++;
                $display("FAIL integrate_after: got %b, want %b", bus.spikes, m_spk);
            end
        end
    endtask

    task automatic test_leak();
        do_reset();
        set_in(1'b1, 40, 0, 100, 2);
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (bus.spikes[0] !== (k == 4)) begin
                n_bad++;
                $display("FAIL leak_edge%0d: got spike0=%b, want %b", k, bus.spikes[0], k == 4);
            end
        end
    endtask

    task automatic test_chain();
        logic [N-1:0] es;
        do_reset();
        set_in(1'b1, 100, 100, 100, 0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            bus.stim_in = '0;
            es = (k <= N) ? N'(1 << (k - 1)) : '0;
            n_cmp++;
            if ({bus.spikes, bus.spike_output, bus.spike_count} !== {es, k == 5, 16'(k >= 6)}) begin
                n_bad++;
                $display("FAIL chain_edge%0d: got spikes=%b out=%b cnt=%0d, want %b %b %0d",
                         k, bus.spikes, bus.spike_output, bus.spike_count, es, k == 5, k >= 6);
            end
        end
    endtask

    task automatic test_refractory();
        bit exp;
        do_reset();
        set_in(1'b1, 100, 0, 100, 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
`ifdef LIF_REFRACTORY_EN
            exp = ((k - 1) % (R + 1)) == 0;
`else
            exp = 1'b1;
`endif
            n_cmp++;
            if (bus.spikes[0] !== exp) begin
                n_bad++;
                $display("FAIL refractory_edge%0d: got spike0=%b, want %b", k, bus.spikes[0], exp);
            end
        end
    endtask

    task automatic test_saturation_enable();
        do_reset();
        set_in(1'b1, 200, 0, 255, 0);
        tick();
        n_cmp++;
        if (bus.spikes !== 4'b0000) begin
            n_bad++;
            $display("FAIL sat_load: got %b, want 0000", bus.spikes);
        end
        set_in(1'b0, 100, 0, 255, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (bus.spikes !== 4'b0000) begin
                n_bad++;
                $display("FAIL sat_disabled%0d: got %b, want 0000", k, bus.spikes);
            end
        end
        bus.enable = 1'b1;
        tick();
        n_cmp++;
        if (bus.spikes !== 4'b0001) begin
            n_bad++;
            $display("FAIL sat_fire: got %b, want 0001", bus.spikes);
        end
        bus.enable = 1'b0;
        tick();
        n_cmp++;
        if (bus.spikes !== 4'b0000) begin
            n_bad++;
            $display("FAIL sat_clear: got %b, want 0000", bus.spikes);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        do_reset();
        set_in(1'b1, 100, 100, 100, 0);
        guard = 0;
        while (m_cnt < 3 && guard < 80) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (bus.spike_count !== 16'd3) begin
            n_bad++;
            $display("FAIL reset_mid_count: got %0d, want 3 (model %0d after %0d edges)",
                     bus.spike_count, m_cnt, guard);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if ({bus.spikes, bus.spike_output, bus.spike_count} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_clear: got spikes=%b out=%b cnt=%0d, want all 0",
                     bus.spikes, bus.spike_output, bus.spike_count);
        end
        set_in(1'b1, 25, 0, 100, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_cmp++;
            if (bus.spikes[0] !== (k == 4)) begin
                n_bad++;
                $display("FAIL reset_mid_restart%0d: got spike0=%b, want %b",
                         k, bus.spikes[0], k == 4);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            reset          = ($urandom_range(0, 99) < 2);
            bus.enable     = ($urandom_range(0, 99) < 85);
            bus.stim_in    = W'($urandom);
            bus.weights    = 24'($urandom);
            bus.threshold  = ($urandom_range(0, 9) == 0) ? W'(0) : W'($urandom);
            bus.leak_shift = 3'($urandom);
            tick();
            n_cmp++;
            if ({bus.spikes, bus.spike_output, bus.spike_count} !== {m_spk, m_out, 16'(m_cnt)}) begin
                n_bad++;
                $display("FAIL random_cycle%0d: got spikes=%b out=%b cnt=%0d, want %b %b %0d",
                         k, bus.spikes, bus.spike_output, bus.spike_count, m_spk, m_out, m_cnt);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 0, 0, 0, 0);
        test_reset();
        test_integrate();
        test_leak();
        test_chain();
        test_refractory();
        test_saturation_enable();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
